// File: rtl/xy2_100_rx.sv
//-----------------------------------------------------------------------------
// xy2_100_rx
//
// Receiver for the XY2-100 galvo command interface. Oversamples the bit clock,
// sync and both data channels in the clk_in domain and de-frames the 20-bit X
// and Y words. Each word must carry a 3'b001 header and have even parity over
// all 20 bits. Accepted 16-bit setpoints go to the position loops. A 16-bit
// status word is serialised back to the host, and link health is reported.
//
// Ports
//   clk_in       20 MHz system clock
//   sys_rstn     asynchronous active-low reset
//   xy_clk       XY2-100 bit clock (~2 MHz, asynchronous to clk_in)
//   xy_sync      frame sync: high for bits 1-19, low for the parity bit
//   xy_x, xy_y   serial X / Y data, MSB first, sampled on xy_clk falling edge
//   status_word  word returned to the host on the status channel
//   xy_status    serial status output, updated on xy_clk rising edge
//   pos_x/pos_y  last accepted X / Y setpoints
//   pos_valid    one-cycle pulse when pos_x / pos_y update
//   frame_err    one-cycle pulse on each rejected frame
//   err_cnt      saturating rejected-frame counter
//   link_up      high while good frames keep arriving within TIMEOUT_CYC
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module xy2_100_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 2000
) (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic        xy_clk,
    input  logic        xy_sync,
    input  logic        xy_x,
    input  logic        xy_y,
    input  logic [15:0] status_word,
    output logic        xy_status,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic        pos_valid,
    output logic        frame_err,
    output logic [15:0] err_cnt,
    output logic        link_up
);

    localparam int unsigned NSYNC   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned WORD_W  = 20;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TMO_W   = 16;
    localparam int unsigned ERR_W   = 16;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(19);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [2:0]       HDR      = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: identical depth keeps all four lines aligned
    // ------------------------------------------------------------------
    logic [NSYNC-1:0] clk_sr;
    logic [NSYNC-1:0] sync_sr;
    logic [NSYNC-1:0] x_sr;
    logic [NSYNC-1:0] y_sr;
    logic             clk_d;

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            clk_sr  <= '0;
            sync_sr <= '0;
            x_sr    <= '0;
            y_sr    <= '0;
            clk_d   <= 1'b0;
        end else begin
            clk_sr  <= {clk_sr[NSYNC-2:0],  xy_clk};
            sync_sr <= {sync_sr[NSYNC-2:0], xy_sync};
            x_sr    <= {x_sr[NSYNC-2:0],    xy_x};
            y_sr    <= {y_sr[NSYNC-2:0],    xy_y};
            clk_d   <= clk_sr[NSYNC-1];
        end
    end

    logic clk_s;
    logic sync_s;
    logic x_s;
    logic y_s;
    logic sample_en;
    logic shift_en;

    assign clk_s     = clk_sr[NSYNC-1];
    assign sync_s    = sync_sr[NSYNC-1];
    assign x_s       = x_sr[NSYNC-1];
    assign y_s       = y_sr[NSYNC-1];
    assign sample_en = clk_d & ~clk_s;
    assign shift_en  = ~clk_d & clk_s;

    // ------------------------------------------------------------------
    // Frame checking
    // ------------------------------------------------------------------
    state_t             state;
    logic [WORD_W-1:0]  xsr;
    logic [WORD_W-1:0]  ysr;
    logic [CNT_W-1:0]   bitcnt;
    logic               ovf;
    logic               seen_low;

    logic x_ok;
    logic y_ok;
    logic frame_good;
    logic good_pulse;

    // Header must be 001 and the whole 20-bit word must have even parity
    assign x_ok       = (xsr[WORD_W-1:WORD_W-3] == HDR) & ~(^xsr);
    assign y_ok       = (ysr[WORD_W-1:WORD_W-3] == HDR) & ~(^ysr);
    assign frame_good = (bitcnt == LAST_BIT) & ~ovf & x_ok & y_ok;
    assign good_pulse = (state == ST_CHECK) & frame_good;

    // Frame state machine; advances on sampled bits, CHECK is a single cycle
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state     <= ST_IDLE;
            xsr       <= '0;
            ysr       <= '0;
            bitcnt    <= '0;
            ovf       <= 1'b0;
            seen_low  <= 1'b0;
            pos_x     <= '0;
            pos_y     <= '0;
            pos_valid <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            pos_valid <= 1'b0;
            frame_err <= 1'b0;

            // A frame only starts after sync has been seen low, so a frame
            // already in flight when reset released is skipped entirely.
            if (sample_en && !sync_s) begin
                seen_low <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (sample_en && sync_s && seen_low) begin
                        xsr    <= {{(WORD_W-1){1'b0}}, x_s};
                        ysr    <= {{(WORD_W-1){1'b0}}, y_s};
                        bitcnt <= CNT_W'(1);
                        ovf    <= 1'b0;
                        state  <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (sample_en) begin
                        if (sync_s) begin
                            if (bitcnt < LAST_BIT) begin
                                xsr    <= {xsr[WORD_W-2:0], x_s};
                                ysr    <= {ysr[WORD_W-2:0], y_s};
                                bitcnt <= bitcnt + CNT_W'(1);
                            end else begin
                                // Too many sync-high bits: freeze and reject
                                ovf <= 1'b1;
                            end
                        end else begin
                            // Sync low marks the parity bit
                            xsr   <= {xsr[WORD_W-2:0], x_s};
                            ysr   <= {ysr[WORD_W-2:0], y_s};
                            state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (frame_good) begin
                        pos_x     <= xsr[DATA_W:1];
                        pos_y     <= ysr[DATA_W:1];
                        pos_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Link timeout: counts cycles since the last good frame
    // ------------------------------------------------------------------
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic             good_seen;

    always_comb begin
        tmo_nxt = tmo_cnt;
        if (good_pulse) begin
            tmo_nxt = '0;
        end else if (tmo_cnt < TMO_MAX) begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tmo_cnt   <= '0;
            good_seen <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            tmo_cnt   <= tmo_nxt;
            good_seen <= good_seen | good_pulse;
            // Registered from next-state values so link_up tracks tmo_cnt
            link_up   <= (good_seen | good_pulse) & (tmo_nxt < TMO_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Status channel: reloaded at every frame check, shifted on xy_clk rise
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] ssr;
    logic [WORD_W-1:0] status_load;

    assign status_load = {HDR, status_word, ^{HDR, status_word}};

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            ssr       <= '0;
            xy_status <= 1'b0;
        end else if (state == ST_CHECK) begin
            ssr <= status_load;
        end else if (shift_en) begin
            xy_status <= ssr[WORD_W-1];
            ssr       <= {ssr[WORD_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_xy2_100_rx.sv
//-----------------------------------------------------------------------------
// tb_xy2_100_rx
//
// Directed bench for xy2_100_rx: good frame, bad parity, bad header, short
// and overrun frames, link timeout, status echo and reset in mid-frame.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_xy2_100_rx;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT_CYC = 2000;
    localparam int          HALF_NS     = 250;   // 2 MHz bit clock

    logic        clk_in = 1'b0;
    logic        sys_rstn;
    logic        xy_clk;
    logic        xy_sync;
    logic        xy_x;
    logic        xy_y;
    logic [15:0] status_word;
    logic        xy_status;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic        pos_valid;
    logic        frame_err;
    logic [15:0] err_cnt;
    logic        link_up;

    int   checks   = 0;
    int   failures = 0;
    int   pv_cnt   = 0;
    int   fe_cnt   = 0;
    int   cyc      = 0;
    int   pv_cyc   = 0;
    logic st_last  = 1'b0;

    xy2_100_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_in      (clk_in),
        .sys_rstn    (sys_rstn),
        .xy_clk      (xy_clk),
        .xy_sync     (xy_sync),
        .xy_x        (xy_x),
        .xy_y        (xy_y),
        .status_word (status_word),
        .xy_status   (xy_status),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_valid   (pos_valid),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt),
        .link_up     (link_up)
    );

    always #25 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk_in) begin
        if (pos_valid === 1'b1) begin
            pv_cnt = pv_cnt + 1;
            pv_cyc = cyc;
        end
        if (frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [2:0] hdr, input logic [15:0] d);
        return {hdr, d, ^{hdr, d}};
    endfunction

    // One bit period: data changes on the rising edge, DUT samples on the fall
    task automatic xy_bit(input logic s, input logic x, input logic y);
        xy_clk  = 1'b1;
        xy_sync = s;
        xy_x    = x;
        xy_y    = y;
        #(HALF_NS);
        st_last = xy_status;
        xy_clk  = 1'b0;
        #(HALF_NS);
    endtask

    // nhigh sync-high bits (MSB first), then one sync-low bit carrying w[0];
    // reset is asserted before bit index rst_at and released before rel_at
    task automatic send_frame(input logic [19:0] xw, input logic [19:0] yw,
                              input int nhigh, input int rst_at, input int rel_at);
        for (int i = 0; i < nhigh; i++) begin
            if (i == rst_at) sys_rstn = 1'b0;
            if (i == rel_at) sys_rstn = 1'b1;
            xy_bit(1'b1, xw[5'(19 - i)], yw[5'(19 - i)]);
        end
        xy_bit(1'b0, xw[0], yw[0]);
        repeat (4) @(negedge clk_in);
    endtask

    int          pv0;
    int          fe0;
    int          guard;
    logic [19:0] st_got;

    initial begin
        sys_rstn    = 1'b0;
        xy_clk      = 1'b0;
        xy_sync     = 1'b0;
        xy_x        = 1'b0;
        xy_y        = 1'b0;
        status_word = 16'h0000;
        st_got      = '0;

        repeat (5) @(negedge clk_in);
        chk("rst_pos_x",     32'(pos_x),     32'h0);
        chk("rst_pos_y",     32'(pos_y),     32'h0);
        chk("rst_pos_valid", 32'(pos_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_err_cnt",   32'(err_cnt),   32'h0);
        chk("rst_link_up",   32'(link_up),   32'h0);
        chk("rst_xy_status", 32'(xy_status), 32'h0);
        sys_rstn = 1'b1;
        repeat (3) @(negedge clk_in);

        // Idle bits with sync low arm the receiver
        xy_bit(1'b0, 1'b0, 1'b0);
        xy_bit(1'b0, 1'b0, 1'b0);
        chk("idle_no_err", 32'(fe_cnt), 32'd0);

        // Good frame
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(mk(3'b001, 16'h1234), mk(3'b001, 16'hABCD), 19, -1, -1);
        chk("good_pos_x",   32'(pos_x),       32'h1234);
        chk("good_pos_y",   32'(pos_y),       32'hABCD);
        chk("good_pv",      32'(pv_cnt - pv0), 32'd1);
        chk("good_fe",      32'(fe_cnt - fe0), 32'd0);
        chk("good_link_up", 32'(link_up),     32'h1);
        chk("good_err_cnt", 32'(err_cnt),     32'h0);

        // Y parity flipped
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(mk(3'b001, 16'h5555), mk(3'b001, 16'h0F0F) ^ 20'h00001, 19, -1, -1);
        chk("par_pos_x",   32'(pos_x),        32'h1234);
        chk("par_pos_y",   32'(pos_y),        32'hABCD);
        chk("par_pv",      32'(pv_cnt - pv0), 32'd0);
        chk("par_fe",      32'(fe_cnt - fe0), 32'd1);
        chk("par_err_cnt", 32'(err_cnt),      32'd1);

        // X header 011, then a 10-bit short frame, then a 20-high overrun
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(mk(3'b011, 16'h1111), mk(3'b001, 16'h2222), 19, -1, -1);
        chk("hdr_err_cnt", 32'(err_cnt), 32'd2);
        send_frame(mk(3'b001, 16'h3333), mk(3'b001, 16'h4444), 10, -1, -1);
        chk("short_err_cnt", 32'(err_cnt), 32'd3);
        send_frame(mk(3'b001, 16'h6666), mk(3'b001, 16'h7777), 20, -1, -1);
        chk("ovf_err_cnt", 32'(err_cnt), 32'd4);
        chk("bad_pv",      32'(pv_cnt - pv0), 32'd0);
        chk("bad_fe",      32'(fe_cnt - fe0), 32'd3);
        chk("bad_pos_x",   32'(pos_x), 32'h1234);

        // Timeout: link_up must drop exactly TIMEOUT_CYC cycles after pos_valid
        pv0 = pv_cnt;
        send_frame(mk(3'b001, 16'h0042), mk(3'b001, 16'h0024), 19, -1, -1);
        chk("tmo_pv", 32'(pv_cnt - pv0), 32'd1);
        guard = 0;
        while (cyc < pv_cyc + int'(TIMEOUT_CYC) - 1 && guard < 3000) begin
            @(negedge clk_in);
            guard = guard + 1;
        end
        chk("tmo_wait_bound", 32'(guard < 3000), 32'h1);
        chk("tmo_link_before", 32'(link_up), 32'h1);
        @(negedge clk_in);
        chk("tmo_link_after", 32'(link_up), 32'h0);
        send_frame(mk(3'b001, 16'h0101), mk(3'b001, 16'h0202), 19, -1, -1);
        chk("tmo_link_restore", 32'(link_up), 32'h1);

        // Status echo: {001, A5C3, p}; header + A5C3 hold 9 ones, so p = 1
        status_word = 16'hA5C3;
        send_frame(mk(3'b001, 16'h0303), mk(3'b001, 16'h0404), 19, -1, -1);
        for (int i = 0; i < 20; i++) begin
            xy_bit(1'b0, 1'b0, 1'b0);
            st_got = {st_got[18:0], st_last};
        end
        chk("status_word", 32'(st_got), 32'h34B87);
        xy_bit(1'b0, 1'b0, 1'b0);
        chk("status_tail", 32'(st_last), 32'h0);

        // Reset asserted at bit 8, released at bit 12: frame must be ignored
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(mk(3'b001, 16'h7E7E), mk(3'b001, 16'h8181), 19, 7, 11);
        chk("rmf_pv",      32'(pv_cnt - pv0), 32'd0);
        chk("rmf_fe",      32'(fe_cnt - fe0), 32'd0);
        chk("rmf_pos_x",   32'(pos_x),   32'h0);
        chk("rmf_err_cnt", 32'(err_cnt), 32'h0);
        chk("rmf_link_up", 32'(link_up), 32'h0);
        send_frame(mk(3'b001, 16'h0001), mk(3'b001, 16'hFFFE), 19, -1, -1);
        chk("rmf2_pos_x", 32'(pos_x),        32'h0001);
        chk("rmf2_pos_y", 32'(pos_y),        32'hFFFE);
        chk("rmf2_pv",    32'(pv_cnt - pv0), 32'd1);
        chk("rmf2_fe",    32'(fe_cnt - fe0), 32'd0);
        chk("rmf2_link",  32'(link_up),      32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
